// File: rtl/bias_array.sv
// bias_array: adds a loaded per-column bias to systolic output data over N_COLS columns, counting rows per tile.
// Define BIAS_SAT_EN for saturating sums; otherwise the sum wraps in two's complement.
module bias_array #(
  parameter int N_COLS = 2,
  parameter int DATA_W = 16,
  parameter int ROW_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bias_load_valid_in,
  output logic                       bias_load_ready_out,
  input  logic [N_COLS*DATA_W-1:0]   bias_scalar_in,
  input  logic [ROW_W-1:0]           bias_num_rows_in,
  input  logic [N_COLS*DATA_W-1:0]   bias_sys_data_in,
  input  logic [N_COLS-1:0]          bias_sys_valid_in,
  output logic [N_COLS*DATA_W-1:0]   bias_z_data_out,
  output logic [N_COLS-1:0]          bias_Z_valid_out,
  output logic                       bias_busy_out,
  output logic                       bias_done_out,
  output logic                       bias_overrun_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] bias_q [N_COLS];
  logic [DATA_W-1:0] z_q [N_COLS];
  logic [DATA_W-1:0] sum [N_COLS];
  logic [ROW_W-1:0]  row_cnt [N_COLS];
  logic [ROW_W-1:0]  num_rows;
  logic [N_COLS-1:0] accept, col_done;
  logic              load;
  assign load = bias_load_valid_in && bias_load_ready_out;
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
`ifdef BIAS_SAT_EN
    logic signed [DATA_W:0] s;
    assign s = $signed(bias_sys_data_in[c*DATA_W +: DATA_W]) + $signed(bias_q[c]);
    // Overflow shows as disagreement between the extension bit and the result sign.
    assign sum[c] = (s[DATA_W] != s[DATA_W-1]) ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
`else
    assign sum[c] = bias_sys_data_in[c*DATA_W +: DATA_W] + bias_q[c];
`endif
    assign accept[c] = (state == RUN) && bias_sys_valid_in[c] && (row_cnt[c] < num_rows);
    assign col_done[c] = (row_cnt[c] + ROW_W'(accept[c])) == num_rows;
    assign bias_z_data_out[c*DATA_W +: DATA_W] = z_q[c];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = load ? ((bias_num_rows_in == '0) ? DONE : RUN) : IDLE;
      RUN:     state_nx = (&col_done) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  assign bias_load_ready_out = rst && (state == IDLE);
  assign bias_busy_out       = state != IDLE;
  assign bias_done_out       = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      num_rows         <= '0;
      bias_Z_valid_out <= '0;
      bias_overrun_out <= 1'b0;
      for (int i = 0; i < N_COLS; i++) begin
        bias_q[i]  <= '0;
        row_cnt[i] <= '0;
        z_q[i]     <= '0;
      end
    end else begin
      state            <= state_nx;
      bias_Z_valid_out <= accept;
      bias_overrun_out <= bias_overrun_out | (|(bias_sys_valid_in & ~accept));
      if (load) num_rows <= bias_num_rows_in;
      for (int i = 0; i < N_COLS; i++) begin
        if (load) begin
          bias_q[i]  <= bias_scalar_in[i*DATA_W +: DATA_W];
          row_cnt[i] <= '0;
        end else if (accept[i]) begin
          row_cnt[i] <= row_cnt[i] + 1'b1;
        end
        if (accept[i]) z_q[i] <= sum[i];
      end
    end
  end
endmodule
